// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: forward encodings, controller states and the shared register-match helper.
package pipe_hazard_ctrl_pkg;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2} fwd_t;
  typedef enum logic [1:0] {RUN, FREEZE, REDIR} state_t;
  // $0 is hardwired, so it never creates a dependency
  function automatic logic hit(input logic [4:0] src, input logic rd, input logic [4:0] dst, input logic wr);
    return rd && wr && src != REG_ZERO && src == dst;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-side view of the hazard controller (stage addresses in, stall/flush/forward out).
interface pipe_hazard_ctrl_if;
  logic [4:0]  RegAddrX_ID, RegAddrY_ID, RegAddrX_EX, RegAddrY_EX;
  logic [4:0]  WriteReg_Addr_EX, WriteReg_Addr_MEM, WriteReg_Addr_WB;
  logic        UseX_ID, UseY_ID, Branch_ID, JumptoReg_ID, Taken_ID;
  logic        RegWrite_EX, RegWrite_MEM, RegWrite_WB, MemRead_EX, MemRead_MEM;
  logic        ICache_stall, DCache_stall;
  logic        Stall_IF, Stall_ID, Stall_EXMEM, Bubble_EX, Flush_IF;
  logic [1:0]  Fwd_X_ID, Fwd_Y_ID, Fwd_X_EX, Fwd_Y_EX;
  logic [31:0] StallCnt, FlushCnt;
  modport master (
    output RegAddrX_ID, RegAddrY_ID, RegAddrX_EX, RegAddrY_EX, WriteReg_Addr_EX, WriteReg_Addr_MEM,
           WriteReg_Addr_WB, UseX_ID, UseY_ID, Branch_ID, JumptoReg_ID, Taken_ID, RegWrite_EX,
           RegWrite_MEM, RegWrite_WB, MemRead_EX, MemRead_MEM, ICache_stall, DCache_stall,
    input  Stall_IF, Stall_ID, Stall_EXMEM, Bubble_EX, Flush_IF, Fwd_X_ID, Fwd_Y_ID, Fwd_X_EX,
           Fwd_Y_EX, StallCnt, FlushCnt
  );
  modport slave (
    input  RegAddrX_ID, RegAddrY_ID, RegAddrX_EX, RegAddrY_EX, WriteReg_Addr_EX, WriteReg_Addr_MEM,
           WriteReg_Addr_WB, UseX_ID, UseY_ID, Branch_ID, JumptoReg_ID, Taken_ID, RegWrite_EX,
           RegWrite_MEM, RegWrite_WB, MemRead_EX, MemRead_MEM, ICache_stall, DCache_stall,
    output Stall_IF, Stall_ID, Stall_EXMEM, Bubble_EX, Flush_IF, Fwd_X_ID, Fwd_Y_ID, Fwd_X_EX,
           Fwd_Y_EX, StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// pipe_hazard_ctrl_fwd_sel: forward source for one operand; MEM beats WB, a load still in MEM cannot forward.
module pipe_hazard_ctrl_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       rd,
  input  logic [4:0] mem_dst,
  input  logic       mem_wr,
  input  logic       mem_ld,
  input  logic [4:0] wb_dst,
  input  logic       wb_wr,
  output logic [1:0] sel,
  output logic       nofwd
);
  logic m_mem, m_wb;
  assign m_mem = hit(src, rd, mem_dst, mem_wr);
  assign m_wb  = hit(src, rd, wb_dst, wb_wr);
  assign nofwd = m_mem && mem_ld;
  assign sel   = m_mem ? (mem_ld ? FWD_RF : FWD_MEM) : (m_wb ? FWD_WB : FWD_RF);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward scheduler for the 5-stage pipeline with cache-wait and redirect tracking.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic              Clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  state_t state, state_n, cur;
  logic redir, redir_n, hz, br, ex_x, ex_y, nx_id, ny_id, unused_nx_ex, unused_ny_ex, flush_ev;
  logic [31:0] stall_cnt, flush_cnt;
  pipe_hazard_ctrl_fwd_sel u_x_id (.src(bus.RegAddrX_ID), .rd(bus.UseX_ID), .mem_dst(bus.WriteReg_Addr_MEM),
    .mem_wr(bus.RegWrite_MEM), .mem_ld(bus.MemRead_MEM), .wb_dst(bus.WriteReg_Addr_WB),
    .wb_wr(bus.RegWrite_WB), .sel(bus.Fwd_X_ID), .nofwd(nx_id));
  pipe_hazard_ctrl_fwd_sel u_y_id (.src(bus.RegAddrY_ID), .rd(bus.UseY_ID), .mem_dst(bus.WriteReg_Addr_MEM),
    .mem_wr(bus.RegWrite_MEM), .mem_ld(bus.MemRead_MEM), .wb_dst(bus.WriteReg_Addr_WB),
    .wb_wr(bus.RegWrite_WB), .sel(bus.Fwd_Y_ID), .nofwd(ny_id));
  // EX consumers never see an unforwardable load: the load-use bubble already separated them
  pipe_hazard_ctrl_fwd_sel u_x_ex (.src(bus.RegAddrX_EX), .rd(1'b1), .mem_dst(bus.WriteReg_Addr_MEM),
    .mem_wr(bus.RegWrite_MEM), .mem_ld(1'b0), .wb_dst(bus.WriteReg_Addr_WB),
    .wb_wr(bus.RegWrite_WB), .sel(bus.Fwd_X_EX), .nofwd(unused_nx_ex));
  pipe_hazard_ctrl_fwd_sel u_y_ex (.src(bus.RegAddrY_EX), .rd(1'b1), .mem_dst(bus.WriteReg_Addr_MEM),
    .mem_wr(bus.RegWrite_MEM), .mem_ld(1'b0), .wb_dst(bus.WriteReg_Addr_WB),
    .wb_wr(bus.RegWrite_WB), .sel(bus.Fwd_Y_EX), .nofwd(unused_ny_ex));
  assign br   = bus.Branch_ID | bus.JumptoReg_ID;
  assign ex_x = hit(bus.RegAddrX_ID, bus.UseX_ID, bus.WriteReg_Addr_EX, bus.RegWrite_EX);
  assign ex_y = hit(bus.RegAddrY_ID, bus.UseY_ID, bus.WriteReg_Addr_EX, bus.RegWrite_EX);
  assign hz   = br ? (ex_x | ex_y | nx_id | ny_id) : ((ex_x | ex_y) & bus.MemRead_EX);
  // the cycle a freeze lifts behaves like the state that was interrupted
  assign cur  = (state == FREEZE && !bus.DCache_stall) ? (redir ? REDIR : RUN) : state;
  always_comb begin
    state_n         = cur;
    redir_n         = redir;
    flush_ev        = 1'b0;
    bus.Stall_IF    = 1'b0;
    bus.Stall_ID    = 1'b0;
    bus.Stall_EXMEM = 1'b0;
    bus.Bubble_EX   = 1'b0;
    bus.Flush_IF    = 1'b0;
    if (bus.DCache_stall) begin
      state_n         = FREEZE;
      bus.Stall_IF    = 1'b1;
      bus.Stall_ID    = 1'b1;
      bus.Stall_EXMEM = 1'b1;
    end else if (cur == REDIR) begin
      bus.Stall_IF = bus.ICache_stall;
      bus.Flush_IF = bus.ICache_stall;
      state_n      = bus.ICache_stall ? REDIR : RUN;
      redir_n      = bus.ICache_stall;
    end else if (hz) begin
      bus.Stall_IF  = 1'b1;
      bus.Stall_ID  = 1'b1;
      bus.Bubble_EX = 1'b1;
    end else if (bus.Taken_ID) begin
      bus.Flush_IF = 1'b1;
      flush_ev     = 1'b1;
      state_n      = bus.ICache_stall ? REDIR : RUN;
      redir_n      = bus.ICache_stall;
    end else if (bus.ICache_stall) begin
      bus.Stall_IF = 1'b1;
      bus.Flush_IF = 1'b1;
    end
  end
  always_ff @(posedge Clk) begin
    if (rst) begin
      state     <= RUN;
      redir     <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      redir     <= redir_n;
      stall_cnt <= stall_cnt + {31'd0, bus.Stall_IF & ~&stall_cnt};
      flush_cnt <= flush_cnt + {31'd0, flush_ev & ~&flush_cnt};
    end
  end
  assign bus.StallCnt = stall_cnt;
  assign bus.FlushCnt = flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scenario tasks drive stage contents per cycle and compare against queued expectations.
module tb_pipe_hazard_ctrl;
  typedef struct packed {
    logic si, sid, sem, bub, fl;
    logic [1:0] fxi, fyi, fxe, fye;
  } exp_t;

  logic Clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   exp_stall = 0;
  exp_t q[$];
  exp_t e, got;

  pipe_hazard_ctrl_if bus();
  pipe_hazard_ctrl dut (.Clk(Clk), .rst(rst), .bus(bus));

  always #5 Clk = ~Clk;

  function automatic exp_t mk(input logic [4:0] c, input logic [1:0] a = 0, input logic [1:0] b = 0,
                              input logic [1:0] d = 0, input logic [1:0] f = 0);
    return {c, a, b, d, f};
  endfunction

  function automatic exp_t obs();
    return {bus.Stall_IF, bus.Stall_ID, bus.Stall_EXMEM, bus.Bubble_EX, bus.Flush_IF,
            bus.Fwd_X_ID, bus.Fwd_Y_ID, bus.Fwd_X_EX, bus.Fwd_Y_EX};
  endfunction

  task automatic idle();
    bus.RegAddrX_ID = 0; bus.RegAddrY_ID = 0; bus.RegAddrX_EX = 0; bus.RegAddrY_EX = 0;
    bus.WriteReg_Addr_EX = 0; bus.WriteReg_Addr_MEM = 0; bus.WriteReg_Addr_WB = 0;
    bus.UseX_ID = 0; bus.UseY_ID = 0; bus.Branch_ID = 0; bus.JumptoReg_ID = 0; bus.Taken_ID = 0;
    bus.RegWrite_EX = 0; bus.RegWrite_MEM = 0; bus.RegWrite_WB = 0;
    bus.MemRead_EX = 0; bus.MemRead_MEM = 0; bus.ICache_stall = 0; bus.DCache_stall = 0;
  endtask

  task automatic prod_ex(input logic [4:0] a, input logic ld);
    bus.WriteReg_Addr_EX = a; bus.RegWrite_EX = 1; bus.MemRead_EX = ld;
  endtask
  task automatic prod_mem(input logic [4:0] a, input logic ld);
    bus.WriteReg_Addr_MEM = a; bus.RegWrite_MEM = 1; bus.MemRead_MEM = ld;
  endtask
  task automatic prod_wb(input logic [4:0] a);
    bus.WriteReg_Addr_WB = a; bus.RegWrite_WB = 1;
  endtask
  task automatic cons_id(input logic [4:0] x, input logic ux, input logic [4:0] y, input logic uy, input logic b);
    bus.RegAddrX_ID = x; bus.UseX_ID = ux; bus.RegAddrY_ID = y; bus.UseY_ID = uy; bus.Branch_ID = b;
  endtask

  task automatic push(input exp_t x);
    q.push_back(x);
    exp_stall += int'(x.si);
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    @(posedge Clk); #1;
    rst = 0;
    exp_stall = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge Clk);
    checks++;
    if (obs() !== '0) begin errors++; $display("FAIL reset_outputs got=%b want=0", obs()); end
    checks++;
    if (bus.StallCnt !== 0) begin errors++; $display("FAIL reset_stallcnt got=%0d want=0", bus.StallCnt); end
    checks++;
    if (bus.FlushCnt !== 0) begin errors++; $display("FAIL reset_flushcnt got=%0d want=0", bus.FlushCnt); end
    @(posedge Clk); #1;
  endtask

  task automatic test_load_use();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      case (i)
        0: begin prod_ex(2, 1); cons_id(2, 1, 4, 1, 0); push(mk(5'b11010)); end
        1: begin prod_mem(2, 1); cons_id(2, 1, 4, 1, 0); push(mk(5'b00000)); end
        default: begin prod_wb(2); bus.RegAddrX_EX = 2; bus.RegAddrY_EX = 4; push(mk(5'b00000, 0, 0, 2, 0)); end
      endcase
      @(negedge Clk);
      got = obs(); e = q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL load_use cyc%0d got=%b want=%b", i, got, e); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_branch_load();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      cons_id(5, 1, 0, 1, 1);
      case (i)
        0: begin prod_ex(5, 1); push(mk(5'b11010)); end
        1: begin prod_mem(5, 1); push(mk(5'b11010)); end
        2: begin prod_wb(5); push(mk(5'b00000, 2)); end
        default: push(mk(5'b00000));
      endcase
      @(negedge Clk);
      got = obs(); e = q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL branch_load cyc%0d got=%b want=%b", i, got, e); end
      @(posedge Clk); #1;
    end
    checks++;
    if (bus.StallCnt !== exp_stall) begin errors++; $display("FAIL branch_load_stallcnt got=%0d want=%0d", bus.StallCnt, exp_stall); end
  endtask

  task automatic test_forward();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      case (i)
        0: begin prod_mem(7, 0); prod_wb(7); cons_id(7, 1, 7, 0, 1); bus.RegAddrX_EX = 7; bus.RegAddrY_EX = 7;
                 push(mk(5'b00000, 1, 0, 1, 1)); end
        1: begin prod_wb(7); cons_id(7, 1, 7, 0, 1); bus.RegAddrX_EX = 7; bus.RegAddrY_EX = 7;
                 push(mk(5'b00000, 2, 0, 2, 2)); end
        2: begin prod_mem(7, 0); prod_wb(7); cons_id(3, 1, 7, 1, 1); bus.RegAddrX_EX = 3; bus.RegAddrY_EX = 7;
                 push(mk(5'b00000, 0, 1, 0, 1)); end
        3: begin prod_ex(9, 0); cons_id(9, 1, 0, 0, 0); bus.JumptoReg_ID = 1; push(mk(5'b11010)); end
        default: begin prod_ex(9, 0); cons_id(9, 1, 0, 0, 0); push(mk(5'b00000)); end
      endcase
      @(negedge Clk);
      got = obs(); e = q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL forward cyc%0d got=%b want=%b", i, got, e); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: begin cons_id(1, 0, 0, 0, 1); bus.Taken_ID = 1; bus.ICache_stall = 1; push(mk(5'b00001)); end
        1, 2, 3: begin bus.ICache_stall = 1; push(mk(5'b10001)); end
        default: push(mk(5'b00000));
      endcase
      @(negedge Clk);
      got = obs(); e = q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL redirect cyc%0d got=%b want=%b", i, got, e); end
      @(posedge Clk); #1;
    end
    checks++;
    if (bus.FlushCnt !== 1) begin errors++; $display("FAIL redirect_flushcnt got=%0d want=1", bus.FlushCnt); end
    checks++;
    if (bus.StallCnt !== exp_stall) begin errors++; $display("FAIL redirect_stallcnt got=%0d want=%0d", bus.StallCnt, exp_stall); end
  endtask

  task automatic test_freeze_in_redir();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      idle();
      case (i)
        0: begin cons_id(1, 0, 0, 0, 1); bus.Taken_ID = 1; bus.ICache_stall = 1; push(mk(5'b00001)); end
        1, 7: begin bus.ICache_stall = 1; push(mk(5'b10001)); end
        8: push(mk(5'b00000));
        default: begin bus.ICache_stall = 1; bus.DCache_stall = 1; prod_ex(2, 1); cons_id(2, 1, 0, 0, 0);
                       push(mk(5'b11100)); end
      endcase
      @(negedge Clk);
      got = obs(); e = q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL freeze_redir cyc%0d got=%b want=%b", i, got, e); end
      @(posedge Clk); #1;
    end
    checks++;
    if (bus.FlushCnt !== 1) begin errors++; $display("FAIL freeze_redir_flushcnt got=%0d want=1", bus.FlushCnt); end
    checks++;
    if (bus.StallCnt !== exp_stall) begin errors++; $display("FAIL freeze_redir_stallcnt got=%0d want=%0d", bus.StallCnt, exp_stall); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      idle();
      prod_ex(0, 1); prod_mem(0, i == 0); prod_wb(0);
      cons_id(0, 1, 0, 1, i == 0);
      push(mk(5'b00000));
      @(negedge Clk);
      got = obs(); e = q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL zero_reg cyc%0d got=%b want=%b", i, got, e); end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      case (i)
        0: begin prod_ex(2, 1); cons_id(2, 1, 0, 0, 0); bus.DCache_stall = 1; push(mk(5'b11100)); end
        1: begin prod_ex(2, 1); cons_id(2, 1, 0, 0, 0); push(mk(5'b11010)); end
        2: begin prod_mem(2, 1); cons_id(2, 1, 0, 0, 0); push(mk(5'b00000)); end
        3: begin bus.ICache_stall = 1; push(mk(5'b10001)); end
        4: begin cons_id(1, 0, 0, 0, 1); bus.Taken_ID = 1; push(mk(5'b00001)); end
        default: push(mk(5'b00000));
      endcase
      @(negedge Clk);
      got = obs(); e = q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL back_to_back cyc%0d got=%b want=%b", i, got, e); end
      @(posedge Clk); #1;
    end
    checks++;
    if (bus.FlushCnt !== 1) begin errors++; $display("FAIL back_to_back_flushcnt got=%0d want=1", bus.FlushCnt); end
    checks++;
    if (bus.StallCnt !== exp_stall) begin errors++; $display("FAIL back_to_back_stallcnt got=%0d want=%0d", bus.StallCnt, exp_stall); end
  endtask

  task automatic test_reset_mid_redir();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      idle();
      bus.ICache_stall = 1;
      if (i == 0) begin
        cons_id(1, 0, 0, 0, 1); bus.Taken_ID = 1; push(mk(5'b00001));
      end else begin
        prod_ex(2, 1); cons_id(2, 1, 0, 0, 0); push(mk(5'b11010));
      end
      @(negedge Clk);
      got = obs(); e = q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_mid cyc%0d got=%b want=%b", i, got, e); end
      @(posedge Clk); #1;
      if (i == 0) begin
        rst = 1;
        @(posedge Clk); #1;
        rst = 0;
      end
    end
    checks++;
    if (bus.FlushCnt !== 0) begin errors++; $display("FAIL reset_mid_flushcnt got=%0d want=0", bus.FlushCnt); end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch_load();
    test_forward();
    test_redirect();
    test_freeze_in_redir();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid_redir();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
